// File: rtl/instr_cache_assoc.sv
// Two-way set-associative instruction cache. Per-set LRU, full-tag compare, whole-cache flush,
// and abort of an outstanding miss. The fill still completes because memory cannot be cancelled.
module instr_cache_assoc #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned LINE_WORDS  = 2,
  parameter int unsigned INDEX_WIDTH = 6
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    fetch_signal,
  input  logic [ADDR_WIDTH-1:0]   fetch_addr,
  output logic                    fetch_done,
  output logic [31:0]             fetch_instr,
  input  logic                    abort_in,
  input  logic                    flush_in,
  output logic                    mem_signal,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic                    mem_done,
  input  logic [32*LINE_WORDS-1:0] mem_data
);
  localparam int unsigned OFF_WIDTH  = $clog2(LINE_WORDS);
  localparam int unsigned DATA_WIDTH = 32 * LINE_WORDS;
  localparam int unsigned TAG_WIDTH  = ADDR_WIDTH - INDEX_WIDTH - OFF_WIDTH - 2;
  localparam int unsigned SETS       = 1 << INDEX_WIDTH;
  localparam int unsigned IDX_LSB    = OFF_WIDTH + 2;
  localparam int unsigned TAG_LSB    = IDX_LSB + INDEX_WIDTH;

  typedef enum logic [1:0] {StIdle, StMiss, StAbortWait} state_e;

  state_e                  state_q, state_d;
  logic                    fetch_done_q, fetch_done_d;
  logic [31:0]             fetch_instr_q, fetch_instr_d;
  logic                    mem_signal_q, mem_signal_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [OFF_WIDTH-1:0]    req_off_q, req_off_d;
  logic [SETS-1:0]         valid0_q, valid0_d, valid1_q, valid1_d;
  logic [SETS-1:0]         lru_q, lru_d;

  logic [TAG_WIDTH-1:0]    tag0_q  [SETS];
  logic [TAG_WIDTH-1:0]    tag1_q  [SETS];
  logic [DATA_WIDTH-1:0]   data0_q [SETS];
  logic [DATA_WIDTH-1:0]   data1_q [SETS];

  logic [OFF_WIDTH-1:0]    f_off;
  logic [INDEX_WIDTH-1:0]  f_idx, m_idx;
  logic [TAG_WIDTH-1:0]    f_tag, m_tag;
  logic                    hit0, hit1, victim;
  logic                    fill_we, fill_way;
  logic                    unused_addr_bits;

  assign f_off = fetch_addr[IDX_LSB-1:2];
  assign f_idx = fetch_addr[TAG_LSB-1:IDX_LSB];
  assign f_tag = fetch_addr[ADDR_WIDTH-1:TAG_LSB];
  assign m_idx = mem_addr_q[TAG_LSB-1:IDX_LSB];
  assign m_tag = mem_addr_q[ADDR_WIDTH-1:TAG_LSB];
  assign unused_addr_bits = ^fetch_addr[1:0];

  assign hit0 = valid0_q[f_idx] && (tag0_q[f_idx] == f_tag);
  assign hit1 = valid1_q[f_idx] && (tag1_q[f_idx] == f_tag);
  // Victim: first invalid way (way0 first), otherwise the LRU way.
  assign victim = !valid0_q[m_idx] ? 1'b0 : (!valid1_q[m_idx] ? 1'b1 : lru_q[m_idx]);

  function automatic logic [31:0] word_sel(input logic [DATA_WIDTH-1:0] line,
                                           input logic [OFF_WIDTH-1:0] off);
    return line[32*off +: 32];
  endfunction

  always_comb begin
    state_d       = state_q;
    fetch_done_d  = 1'b0;
    fetch_instr_d = fetch_instr_q;
    mem_signal_d  = mem_signal_q;
    mem_addr_d    = mem_addr_q;
    req_off_d     = req_off_q;
    valid0_d      = valid0_q;
    valid1_d      = valid1_q;
    lru_d         = lru_q;
    fill_we       = 1'b0;
    fill_way      = victim;

    unique case (state_q)
      StIdle: begin
        // A completion pulse in flight means the requester may still show the old request.
        if (fetch_signal && !abort_in && !fetch_done_q) begin
          if (hit0 || hit1) begin
            fetch_done_d   = 1'b1;
            fetch_instr_d  = hit0 ? word_sel(data0_q[f_idx], f_off)
                                  : word_sel(data1_q[f_idx], f_off);
            lru_d[f_idx]   = hit0;
          end else begin
            mem_signal_d = 1'b1;
            mem_addr_d   = {fetch_addr[ADDR_WIDTH-1:IDX_LSB], {IDX_LSB{1'b0}}};
            req_off_d    = f_off;
            state_d      = StMiss;
          end
        end
      end
      StMiss, StAbortWait: begin
        if (mem_done) begin
          if (!flush_in) begin
            fill_we = 1'b1;
            if (victim) valid1_d[m_idx] = 1'b1;
            else        valid0_d[m_idx] = 1'b1;
            lru_d[m_idx] = ~victim;
          end
          mem_signal_d = 1'b0;
          state_d      = StIdle;
          if (state_q == StMiss && !abort_in) begin
            fetch_done_d  = 1'b1;
            fetch_instr_d = word_sel(mem_data, req_off_q);
          end
        end else if (state_q == StMiss && abort_in) begin
          state_d = StAbortWait;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush_in) begin
      valid0_d = '0;
      valid1_d = '0;
      lru_d    = '0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= StIdle;
      fetch_done_q  <= 1'b0;
      fetch_instr_q <= '0;
      mem_signal_q  <= 1'b0;
      mem_addr_q    <= '0;
      req_off_q     <= '0;
      valid0_q      <= '0;
      valid1_q      <= '0;
      lru_q         <= '0;
    end else if (rdy_in) begin
      state_q       <= state_d;
      fetch_done_q  <= fetch_done_d;
      fetch_instr_q <= fetch_instr_d;
      mem_signal_q  <= mem_signal_d;
      mem_addr_q    <= mem_addr_d;
      req_off_q     <= req_off_d;
      valid0_q      <= valid0_d;
      valid1_q      <= valid1_d;
      lru_q         <= lru_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && fill_we) begin
      if (fill_way) begin
        tag1_q[m_idx]  <= m_tag;
        data1_q[m_idx] <= mem_data;
      end else begin
        tag0_q[m_idx]  <= m_tag;
        data0_q[m_idx] <= mem_data;
      end
    end
  end

  assign fetch_done  = fetch_done_q;
  assign fetch_instr = fetch_instr_q;
  assign mem_signal  = mem_signal_q;
  assign mem_addr    = mem_addr_q;

endmodule
